// File: rtl/key_io_ctrl.sv
// rtl/key_io_ctrl.sv - memory-mapped debounced key device (optional irq via KEY_IRQ_EN)
module key_io_ctrl #(
    parameter int unsigned       DBITS           = 32,
    parameter int unsigned       KEYBITS         = 4,
    parameter logic [DBITS-1:0]  ADDRKDATA       = DBITS'(32'hFFFFF080),
    parameter logic [DBITS-1:0]  ADDRKCTRL       = DBITS'(32'hFFFFF084),
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter int unsigned       CNTBITS         = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [DBITS-1:0]   addr,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [DBITS-1:0]   wr_data,
    output logic [DBITS-1:0]   rd_data,
    output logic               hit,
    output logic               irq
);

    localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

    logic [KEYBITS-1:0] s1;
    logic [KEYBITS-1:0] s2;
    logic [KEYBITS-1:0] cand;
    logic [KEYBITS-1:0] kdata;
    logic [CNTBITS-1:0] cnt;
    logic               ready;
    logic               overrun;
    logic               ie_bit;

    logic kdata_sel;
    logic kctrl_sel;
    logic change_evt;
    logic clr_ready;
    logic clr_overrun;
    logic unused_wr_bits;

    assign kdata_sel   = (addr == ADDRKDATA);
    assign kctrl_sel   = (addr == ADDRKCTRL);
    assign hit         = kdata_sel | kctrl_sel;

    // A change event fires on the edge where the candidate has been stable for the full window.
    assign change_evt  = (s2 == cand) && (cand != kdata) && (cnt == CNT_LAST);
    assign clr_ready   = (rd_en & kdata_sel) | (wr_en & kctrl_sel & ~wr_data[0]);
    assign clr_overrun = wr_en & kctrl_sel & ~wr_data[1];

    // Only bits 0, 1 and 4 of store data carry meaning.
    assign unused_wr_bits = ^wr_data;

    // Two-flop synchroniser; keys are inverted so a pressed key reads as 1 inside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= ~KEY;
            s2 <= s1;
        end
    end

    // Whole-vector debounce: any movement restarts the window, a full stable window commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand  <= '0;
            kdata <= '0;
            cnt   <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cand != kdata) begin
            if (cnt == CNT_LAST) begin
                kdata <= cand;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Sticky status: a change event beats a same-edge clear and only overruns an uncleared ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (change_evt) begin
                ready <= 1'b1;
            end else if (clr_ready) begin
                ready <= 1'b0;
            end
            if (change_evt && ready && !clr_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef KEY_IRQ_EN
    logic ie;
    logic irq_q;

    assign ie_bit = ie;
    assign irq    = irq_q;

    // Interrupt enable and a registered request, so irq trails ready/ie by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie    <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= ready & ie;
            if (wr_en && kctrl_sel) begin
                ie <= wr_data[4];
            end
        end
    end
`else
    assign ie_bit = 1'b0;
    assign irq    = 1'b0;
`endif

    // Read mux; unmapped addresses return zero so the MEM stage can OR or select freely.
    always_comb begin
        rd_data = '0;
        if (kdata_sel) begin
            rd_data = {{(DBITS-KEYBITS){1'b0}}, kdata};
        end else if (kctrl_sel) begin
            rd_data = {{(DBITS-5){1'b0}}, ie_bit, 2'b00, overrun, ready};
        end
    end

endmodule

// File: tb/tb_key_io_ctrl.sv
// tb/tb_key_io_ctrl.sv - randomized and directed self-checking bench for key_io_ctrl
module tb_key_io_ctrl;

    localparam int          N      = 4;
    localparam logic [31:0] A_KD   = 32'hFFFFF080;
    localparam logic [31:0] A_KC   = 32'hFFFFF084;
    localparam logic [31:0] A_MISS = 32'hFFFFF088;
`ifdef KEY_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        hit;
    logic        irq;

    int n_err = 0;
    int n_chk = 0;

    // reference model: pressed vector observed by the debouncer arrives two edges after KEY
    logic [3:0] m_d1, m_d2, m_last, m_kdata;
    int         m_run;
    bit         m_ready, m_over, m_ie, m_irq;

    key_io_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wr_data(wr_data), .rd_data(rd_data), .hit(hit), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_last = 0; m_run = 0; m_kdata = 0;
        m_ready = 0; m_over = 0; m_ie = 0; m_irq = 0;
    endtask

    task automatic model_edge(input logic [31:0] a, input bit r, input bit w, input logic [31:0] d);
        logic [3:0] seen;
        bit evt, clr_r, clr_o, n_ready, n_over;
        seen = m_d2;
        m_d2 = m_d1;
        m_d1 = ~KEY;
        if (seen == m_last) m_run++;
        else begin m_last = seen; m_run = 1; end
        // a value must be seen on N+1 consecutive edges before it is committed
        evt = (m_run == N + 1) && (seen != m_kdata);
        if (evt) m_kdata = seen;
        clr_r = (r && a == A_KD) || (w && a == A_KC && !d[0]);
        clr_o = w && a == A_KC && !d[1];
        n_ready = evt ? 1'b1 : (clr_r ? 1'b0 : m_ready);
        n_over  = (evt && m_ready && !clr_r) ? 1'b1 : (clr_o ? 1'b0 : m_over);
        m_irq   = IRQ && m_ready && m_ie;
        if (IRQ && w && a == A_KC) m_ie = d[4];
        m_ready = n_ready;
        m_over  = n_over;
    endtask

    task automatic step(input logic [31:0] a, input bit r, input bit w, input logic [31:0] d);
        addr = a; rd_en = r; wr_en = w; wr_data = d;
        @(posedge clk);
        model_edge(a, r, w, d);
        @(negedge clk);
        rd_en = 0; wr_en = 0; wr_data = 0;
    endtask

    task automatic idle();
        step(32'h0, 0, 0, 32'h0);
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v, output logic h);
        addr = a; rd_en = 0; wr_en = 0;
        #1;
        v = rd_data;
        h = hit;
    endtask

    task automatic test_reset();
        logic [31:0] v; logic h;
        reset = 1; KEY = 4'hF; addr = 0; rd_en = 0; wr_en = 0; wr_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        peek(A_KD, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_kdata got=%h exp=%h", v, 32'h0); end
        n_chk++; if (h !== 1'b1) begin n_err++; $display("FAIL reset_hit_kd got=%b exp=1", h); end
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_kctrl got=%h exp=%h", v, 32'h0); end
        n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset = 0;
        repeat (8) idle();
    endtask

    task automatic test_glitch();
        logic [31:0] v; logic h;
        KEY = 4'hE;
        for (int e = 1; e <= 13; e++) begin
            if (e == 4) KEY = 4'hF;
            idle();
            peek(A_KD, v, h);
            n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL glitch_kdata edge=%0d got=%h exp=0", e, v); end
        end
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL glitch_ready got=%h exp=0", v); end
    endtask

    task automatic test_debounce();
        logic [31:0] v; logic h;
        KEY = 4'hE;
        for (int e = 1; e <= 7; e++) begin
            idle();
            peek(A_KD, v, h);
            n_chk++;
            if (v !== ((e >= 7) ? 32'h1 : 32'h0)) begin
                n_err++; $display("FAIL debounce_kdata edge=%0d got=%h exp=%h", e, v, (e >= 7) ? 32'h1 : 32'h0);
            end
        end
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h1) begin n_err++; $display("FAIL debounce_kctrl got=%h exp=1", v); end
    endtask

    task automatic test_overrun();
        logic [31:0] v; logic h;
        KEY = 4'hC;
        repeat (7) idle();
        peek(A_KD, v, h);
        n_chk++; if (v !== 32'h3) begin n_err++; $display("FAIL overrun_kdata got=%h exp=3", v); end
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h3) begin n_err++; $display("FAIL overrun_kctrl got=%h exp=3", v); end
        step(A_KC, 0, 1, 32'h0);
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL overrun_clear got=%h exp=0", v); end
    endtask

    task automatic test_clear_collision();
        logic [31:0] v; logic h;
        KEY = 4'hF;
        repeat (7) idle();
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h1) begin n_err++; $display("FAIL collide_pre got=%h exp=1", v); end
        KEY = 4'h7;
        repeat (6) idle();
        step(A_KD, 1, 0, 32'h0);
        peek(A_KD, v, h);
        n_chk++; if (v !== 32'h8) begin n_err++; $display("FAIL collide_kdata got=%h exp=8", v); end
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h1) begin n_err++; $display("FAIL collide_kctrl got=%h exp=1", v); end
    endtask

    task automatic test_irq();
        logic [31:0] v; logic h;
        step(A_KC, 0, 1, 32'h0);
        step(A_KC, 0, 1, 32'h11);
        peek(A_KC, v, h);
        n_chk++; if (v !== (IRQ ? 32'h10 : 32'h0)) begin n_err++; $display("FAIL irq_ie got=%h exp=%h", v, IRQ ? 32'h10 : 32'h0); end
        KEY = 4'hF;
        repeat (7) idle();
        peek(A_KC, v, h);
        n_chk++; if (v !== (IRQ ? 32'h11 : 32'h1)) begin n_err++; $display("FAIL irq_ready got=%h exp=%h", v, IRQ ? 32'h11 : 32'h1); end
        n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_lag got=%b exp=0", irq); end
        idle();
        n_chk++; if (irq !== IRQ) begin n_err++; $display("FAIL irq_set got=%b exp=%b", irq, IRQ); end
        step(A_KD, 1, 0, 32'h0);
        n_chk++; if (irq !== IRQ) begin n_err++; $display("FAIL irq_hold got=%b exp=%b", irq, IRQ); end
        idle();
        n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got=%b exp=0", irq); end
        step(A_KC, 0, 1, 32'h0);
    endtask

    task automatic test_bus();
        logic [31:0] v; logic h;
        KEY = 4'hE;
        repeat (7) idle();
        peek(A_MISS, v, h);
        n_chk++; if (h !== 1'b0 || v !== 32'h0) begin n_err++; $display("FAIL miss_read got=%b/%h exp=0/0", h, v); end
        step(A_MISS, 1, 1, 32'h0);
        step(A_KD, 0, 1, 32'h0);
        step(A_KC, 1, 0, 32'h0);
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h1) begin n_err++; $display("FAIL bus_noeffect got=%h exp=1", v); end
        peek(A_KD, v, h);
        n_chk++; if (v !== 32'h1) begin n_err++; $display("FAIL bus_kd_write got=%h exp=1", v); end
        step(A_KC, 1, 1, 32'h2);
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL bus_rdwr got=%h exp=0", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v; logic h;
        KEY = 4'h0;
        repeat (3) idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        peek(A_KD, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL rstmid_kdata got=%h exp=0", v); end
        peek(A_KC, v, h);
        n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL rstmid_kctrl got=%h exp=0", v); end
        reset = 0;
        for (int e = 1; e <= 7; e++) begin
            idle();
            peek(A_KD, v, h);
            n_chk++;
            if (v !== ((e >= 7) ? 32'hF : 32'h0)) begin
                n_err++; $display("FAIL rstmid_requal edge=%0d got=%h exp=%h", e, v, (e >= 7) ? 32'hF : 32'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, a, d; logic h; bit r, w; int hold, op;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                KEY  = 4'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            op = $urandom_range(0, 9);
            a = 32'h0; r = 0; w = 0; d = $urandom & 32'h0000_0013;
            case (op)
                0: begin a = A_KD; r = 1; end
                1: begin a = A_KC; w = 1; end
                2: begin a = A_KC; r = 1; end
                3: begin a = A_KD; w = 1; end
                4: begin a = A_MISS; r = 1; w = 1; d = 32'h0; end
                default: ;
            endcase
            step(a, r, w, d);
            peek(A_KD, v, h);
            n_chk++; if (v !== {28'h0, m_kdata}) begin n_err++; $display("FAIL rand_kdata i=%0d got=%h exp=%h", i, v, {28'h0, m_kdata}); end
            peek(A_KC, v, h);
            n_chk++;
            if (v !== {27'h0, m_ie, 2'b00, m_over, m_ready}) begin
                n_err++; $display("FAIL rand_kctrl i=%0d got=%h exp=%h", i, v, {27'h0, m_ie, 2'b00, m_over, m_ready});
            end
            n_chk++; if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, irq, m_irq); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_debounce();
        test_overrun();
        test_clear_collision();
        test_irq();
        test_bus();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
